// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NDIG  = 8;
    localparam int SEL_W = 3;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_enc.sv
// Combinational hex nibble to 7-segment glyph encoder.
module seg_hex_enc
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH[nib];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with dead-time between digits
// and tear-free frame updates applied at the frame wrap or while idle.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int DEAD  = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  dp_mask,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pend
);

    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_M1 = CNT_W'(DEAD - 1);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(NDIG - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_data_q, buf_data_d, shd_data_q, shd_data_d;
    logic [7:0]         buf_blank_q, buf_blank_d, shd_blank_q, shd_blank_d;
    logic [7:0]         buf_dp_q, buf_dp_d, shd_dp_q, shd_dp_d;
    logic               pend_q, pend_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               fd_q, fd_d;
    logic               frame_end;
    logic               apply;
    logic [3:0]         nib_d;
    logic [6:0]         glyph_d;

    seg_hex_enc u_enc (
        .nib   (nib_d),
        .glyph (glyph_d)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        buf_data_d  = buf_data_q;
        buf_blank_d = buf_blank_q;
        buf_dp_d    = buf_dp_q;
        shd_data_d  = shd_data_q;
        shd_blank_d = shd_blank_q;
        shd_dp_d    = shd_dp_q;
        pend_d      = pend_q;

        frame_end = (state_q == SHOW) && (sel_q == LAST) && (cnt_q == DIV_M1);

        if (!en) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == DEAD_M1) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DIV_M1) begin
                        state_d = BLANK;
                        sel_d   = sel_q + SEL_W'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // The buffer always mirrors the latest load, so applying it also covers
        // a load landing on the apply cycle itself.
        if (load) begin
            buf_data_d  = data;
            buf_blank_d = blank_mask;
            buf_dp_d    = dp_mask;
            pend_d      = 1'b1;
        end

        apply = (state_q == IDLE) || (en && frame_end);
        if (apply) begin
            shd_data_d  = buf_data_d;
            shd_blank_d = buf_blank_d;
            shd_dp_d    = buf_dp_d;
            pend_d      = 1'b0;
        end

        // Outputs are registered from next-state values so they line up with state.
        nib_d = shd_data_d[{sel_d, 2'b00} +: 4];
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_d == SHOW) begin
            seg_d = shd_blank_d[sel_d] ? 7'h00 : glyph_d;
            dp_d  = shd_dp_d[sel_d];
        end
        fd_d = (state_d == SHOW) && (sel_d == LAST) && (cnt_d == DIV_M1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            buf_data_q  <= '0;
            buf_blank_q <= '0;
            buf_dp_q    <= '0;
            shd_data_q  <= '0;
            shd_blank_q <= '0;
            shd_dp_q    <= '0;
            pend_q      <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            buf_data_q  <= buf_data_d;
            buf_blank_q <= buf_blank_d;
            buf_dp_q    <= buf_dp_d;
            shd_data_q  <= shd_data_d;
            shd_blank_q <= shd_blank_d;
            shd_dp_q    <= shd_dp_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            fd_q        <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model plus directed literal checks.
module tb_seg_scan_ctrl;

    localparam int DIV  = 4;
    localparam int DEAD = 1;
    localparam int S    = DIV + DEAD;
    localparam int F    = 8 * S;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [31:0] data;
    logic [7:0]  blank_mask, dp_mask;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp, frame_done, pend;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: idle flag, cycle count since scan start, frames.
    bit          m_idle = 1'b1;
    int          m_r = 0;
    logic [31:0] m_sd = 0, m_bd = 0;
    logic [7:0]  m_sb = 0, m_bb = 0, m_sp = 0, m_bp = 0;
    bit          m_pend = 1'b0;

    seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data       (data),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit fe, ap;
        if (!rst_n) begin
            m_idle = 1'b1; m_r = 0; m_pend = 1'b0;
            m_sd = 0; m_bd = 0; m_sb = 0; m_bb = 0; m_sp = 0; m_bp = 0;
        end else begin
            fe = !m_idle && (m_r % F == F - 1);
            ap = m_idle || (en && fe);
            if (load) begin
                m_bd = data; m_bb = blank_mask; m_bp = dp_mask; m_pend = 1'b1;
            end
            if (ap) begin
                m_sd = m_bd; m_sb = m_bb; m_sp = m_bp; m_pend = 1'b0;
            end
            if (!en) m_idle = 1'b1;
            else if (m_idle) begin m_idle = 1'b0; m_r = 0; end
            else m_r++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        data = d; blank_mask = b; dp_mask = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run_to_pos(input int pos);
        int n = 0;
        tick();
        while ((m_idle || (m_r % F != pos)) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL run_to_pos timeout pos=%0d", pos);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int p, d, ph;
            logic [2:0] esel;
            logic [6:0] eseg;
            logic edp, efd;
            esel = 0; eseg = 0; edp = 0; efd = 0;
            if (!m_idle) begin
                p  = m_r % F;
                d  = p / S;
                ph = p % S;
                esel = 3'(d);
                if (ph >= DEAD) begin
                    eseg = m_sb[d] ? 7'h00 : gl[(m_sd >> (4 * d)) & 32'hF];
                    edp  = m_sp[d];
                end
                efd = (p == F - 1);
            end
            check("sel", 32'(sel), 32'(esel));
            check("seg", 32'(seg), 32'(eseg));
            check("dp", 32'(dp), 32'(edp));
            check("frame_done", 32'(frame_done), 32'(efd));
            check("pend", 32'(pend), 32'(m_pend));
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0;
        data = 0; blank_mask = 0; dp_mask = 0;
        tick();
        chk_on = 1'b1;
        tick();
        check("rst_sel", 32'(sel), 0);
        check("rst_seg", 32'(seg), 0);
        check("rst_pend", 32'(pend), 0);
        rst_n = 1'b1;
        tick();

        // Basic scan of 76543210
        do_load(32'h76543210, 8'h00, 8'h00);
        check("idle_load_pend", 32'(pend), 0);
        en = 1'b1;
        tick();
        check("first_blank_seg", 32'(seg), 0);
        run_to_pos(11);
        check("d2_sel", 32'(sel), 2);
        check("d2_seg", 32'(seg), 32'h5B);
        run_to_pos(39);
        check("fd_lit", 32'(frame_done), 1);
        check("d7_seg", 32'(seg), 32'h07);

        // Tear-free update mid-frame
        run_to_pos(16);
        do_load(32'hFFFFFFFF, 8'h00, 8'h00);
        check("pend_set", 32'(pend), 1);
        run_to_pos(39);
        check("old_d7", 32'(seg), 32'h07);
        run_to_pos(1);
        check("new_d0", 32'(seg), 32'h71);
        check("pend_clr", 32'(pend), 0);

        // Last load wins
        run_to_pos(10);
        do_load(32'h11111111, 8'h00, 8'h00);
        run_to_pos(15);
        do_load(32'h22222222, 8'h00, 8'h00);
        run_to_pos(1);
        check("last_wins_d0", 32'(seg), 32'h5B);
        run_to_pos(36);
        check("last_wins_d7", 32'(seg), 32'h5B);

        // Masks
        do_load(32'h22222222, 8'h81, 8'h02);
        run_to_pos(1);
        check("blank_d0", 32'(seg), 0);
        run_to_pos(5);
        check("dp_blankphase", 32'(dp), 0);
        tick();
        check("dp_d1", 32'(dp), 1);
        check("seg_d1", 32'(seg), 32'h5B);
        run_to_pos(37);
        check("blank_d7", 32'(seg), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 49) != 0);
            load = ($urandom_range(0, 19) == 0);
            data = $urandom;
            blank_mask = 8'($urandom);
            dp_mask = 8'($urandom);
            tick();
        end
        en = 1'b1; load = 1'b0;

        // Drop enable during digit 5 SHOW, load while idle, re-enable
        run_to_pos(27);
        en = 1'b0;
        tick();
        check("idle_sel", 32'(sel), 0);
        check("idle_seg", 32'(seg), 0);
        do_load(32'h89ABCDEF, 8'h00, 8'h00);
        check("idle_apply_pend", 32'(pend), 0);
        en = 1'b1;
        tick();
        check("reen_sel", 32'(sel), 0);
        check("reen_seg", 32'(seg), 0);
        tick();
        check("reen_d0", 32'(seg), 32'h71);

        // Reset mid-frame with a pending frame
        run_to_pos(12);
        do_load(32'h55555555, 8'hFF, 8'hFF);
        check("pend_before_rst", 32'(pend), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_seg", 32'(seg), 0);
        check("rst_mid_pend", 32'(pend), 0);
        check("rst_mid_sel", 32'(sel), 0);
        run_to_pos(1);
        check("zero_d0", 32'(seg), 32'h3F);
        run_to_pos(36);
        check("zero_d7", 32'(seg), 32'h3F);
        tick();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
